// File: rtl/pipeline_controller_if.sv
// Stall/flush handshake bundle between the pipeline stages and the stall/flush sequencer.
// The master side is the pipeline; the slave side is the controller.
interface pipeline_controller_if #(
    parameter int unsigned COUNTER_WIDTH = 32
);
    logic                     id_stall_request;
    logic                     ex_stall_request;
    logic                     mem_stall_request;
    logic                     flush_request;
    logic [31:0]              flush_pc;
    logic                     counter_clear;
    logic [5:0]               stall;
    logic                     flush;
    logic                     pc_redirect;
    logic [31:0]              new_pc;
    logic [COUNTER_WIDTH-1:0] stall_cycles;
    logic                     bus_timeout;

    modport master (
        output id_stall_request, ex_stall_request, mem_stall_request,
        output flush_request, flush_pc, counter_clear,
        input  stall, flush, pc_redirect, new_pc, stall_cycles, bus_timeout
    );

    modport slave (
        input  id_stall_request, ex_stall_request, mem_stall_request,
        input  flush_request, flush_pc, counter_clear,
        output stall, flush, pc_redirect, new_pc, stall_cycles, bus_timeout
    );
endinterface

// File: rtl/pipeline_controller.sv
// Five-stage pipeline stall/flush sequencer with stalled-cycle counter and memory-bus timeout.
//   state   | meaning
//   RUN     | normal operation, stall from highest-priority request
//   PENDING | flush accepted during a memory wait, holding until the wait ends
//   FLUSH   | one-cycle flush and PC redirect to the latched target
module pipeline_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned COUNTER_WIDTH  = 32
) (
    input logic            clock,
    input logic            reset,
    pipeline_controller_if.slave bus
);
    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
    localparam logic [1:0] ST_FLUSH   = 2'd2;

    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_NONE = 6'b000000;

    localparam logic [7:0]               TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);
    localparam logic [COUNTER_WIDTH-1:0] CYCLES_MAX    = '1;

    logic [1:0]               state;
    logic [1:0]               state_next;
    logic [5:0]               stall_vec;
    logic [31:0]              pc_q;
    logic [COUNTER_WIDTH-1:0] cycles_q;
    logic [7:0]               wait_q;
    logic [7:0]               wait_next;
    logic                     timeout_q;

    always_comb begin
        state_next = state;
        stall_vec  = STALL_NONE;
        case (state)
            ST_RUN: begin
                if (bus.flush_request) begin
                    stall_vec  = STALL_MEM;
                    state_next = bus.mem_stall_request ? ST_PENDING : ST_FLUSH;
                end else if (bus.mem_stall_request) begin
                    stall_vec = STALL_MEM;
                end else if (bus.ex_stall_request) begin
                    stall_vec = STALL_EX;
                end else if (bus.id_stall_request) begin
                    stall_vec = STALL_ID;
                end
            end
            ST_PENDING: begin
                stall_vec = STALL_MEM;
                if (!bus.mem_stall_request) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_next = ST_RUN;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // Wait counter holds at the limit so a long wait keeps the timeout asserted without wrapping.
    always_comb begin
        wait_next = 8'd0;
        if (bus.mem_stall_request) begin
            wait_next = (wait_q >= TIMEOUT_LIMIT) ? wait_q : wait_q + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_RUN;
            pc_q      <= 32'h0;
            cycles_q  <= '0;
            wait_q    <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state  <= state_next;
            wait_q <= wait_next;
            if (state == ST_RUN && bus.flush_request) begin
                pc_q <= bus.flush_pc;
            end
            if (bus.counter_clear) begin
                cycles_q <= '0;
            end else if (stall_vec != STALL_NONE && cycles_q != CYCLES_MAX) begin
                cycles_q <= cycles_q + COUNTER_WIDTH'(1);
            end
            if (bus.counter_clear) begin
                timeout_q <= 1'b0;
            end else if (wait_next == TIMEOUT_LIMIT) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign bus.stall        = stall_vec;
    assign bus.flush        = (state == ST_FLUSH);
    assign bus.pc_redirect  = (state == ST_FLUSH);
    assign bus.new_pc       = pc_q;
    assign bus.stall_cycles = cycles_q;
    assign bus.bus_timeout  = timeout_q;
endmodule
